// File: rtl/alu_pkg.sv
// Shared encodings for the ALU sequencer.
// Op codes, FSM states and flag bit positions.
package alu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADD,
    ST_NEG,
    ST_MUL,
    ST_DONE
  } state_t;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/rca.sv
// 8-bit ripple-carry adder, carry-in tied low.
// Exposes sum, carry out and its own ZNCV view.
module rca
  import alu_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] sum,
  output logic       cout,
  output logic [3:0] flags
);

  logic c;

  // bitwise carry chain
  always_comb begin
    c   = 1'b0;
    sum = '0;
    for (int i = 0; i < 8; i++) begin
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

  // flags of the plain addition
  always_comb begin
    flags         = '0;
    flags[FLAG_Z] = (sum == 8'd0);
    flags[FLAG_N] = sum[7];
    flags[FLAG_C] = cout;
    flags[FLAG_V] = (a[7] == b[7]) & (sum[7] != a[7]);
  end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Multi-cycle ADD/SUB/MUL sequencer around
// one shared ripple adder.
module alu_seq_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   operand_a,
  input  logic [WIDTH-1:0]   operand_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic [3:0]         flags,
  output logic               err
);

  localparam int MUL_ITERS = WIDTH;
  localparam int CW = $clog2(MUL_ITERS);

  state_t state, state_nx;

  logic [1:0]         op_q;
  logic [WIDTH-1:0]   a_q, b_q, hi, lo;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] res_q;
  logic [3:0]         flg_q;
  logic               err_q;

  logic [WIDTH-1:0]   add_x, add_y, sum;
  logic               cout;
  logic [3:0]         unused_flags;
  logic               is_sub, accept, last_iter;
  logic [WIDTH:0]     mul_cs;
  logic [2*WIDTH-1:0] prod_nx;
  logic [3:0]         alu_flg, mul_flg;

  assign is_sub    = (op_q == OP_SUB);
  assign in_ready  = (state == ST_IDLE) & ~RST;
  assign accept    = in_valid & in_ready;
  assign last_iter = (cnt == CW'(MUL_ITERS - 1));

  assign out_valid = (state == ST_DONE);
  assign result    = res_q;
  assign flags     = flg_q;
  assign err       = err_q;

  rca u_rca (
    .a     (add_x),
    .b     (add_y),
    .sum   (sum),
    .cout  (cout),
    .flags (unused_flags)
  );

  // operand select; hi doubles as t for SUB
  always_comb begin
    add_x = a_q;
    add_y = b_q;
    if (state == ST_NEG) begin
      add_x = ~b_q;
      add_y = WIDTH'(1);
    end else if (state == ST_MUL || is_sub) begin
      add_y = hi;
    end
  end

  // result flags and next shift-add product
  always_comb begin
    alu_flg         = '0;
    alu_flg[FLAG_Z] = (sum == '0);
    alu_flg[FLAG_N] = sum[WIDTH-1];
    alu_flg[FLAG_C] = cout;
    alu_flg[FLAG_V] = is_sub
      ? (a_q[WIDTH-1] != b_q[WIDTH-1]) & (sum[WIDTH-1] != a_q[WIDTH-1])
      : (a_q[WIDTH-1] == b_q[WIDTH-1]) & (sum[WIDTH-1] != a_q[WIDTH-1]);
    mul_cs  = lo[0] ? {cout, sum} : {1'b0, hi};
    prod_nx = {mul_cs, lo[WIDTH-1:1]};
    mul_flg         = '0;
    mul_flg[FLAG_Z] = (prod_nx == '0);
    mul_flg[FLAG_C] = |prod_nx[2*WIDTH-1:WIDTH];
  end

  // state register
  always_ff @(posedge CLK) begin
    if (RST) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // next-state decode
  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          unique case (op)
            OP_ADD:  state_nx = ST_ADD;
            OP_SUB:  state_nx = ST_NEG;
            OP_MUL:  state_nx = ST_MUL;
            OP_RSV:  state_nx = ST_DONE;
            default: state_nx = ST_IDLE;
          endcase
        end
      end
      ST_NEG:  state_nx = ST_ADD;
      ST_ADD:  state_nx = ST_DONE;
      ST_MUL:  if (last_iter) state_nx = ST_DONE;
      ST_DONE: if (out_ready) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // operand latch, shift register and result capture
  always_ff @(posedge CLK) begin
    if (RST) begin
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      hi    <= '0;
      lo    <= '0;
      cnt   <= '0;
      res_q <= '0;
      flg_q <= '0;
      err_q <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            op_q <= op;
            a_q  <= operand_a;
            b_q  <= operand_b;
            hi   <= '0;
            lo   <= operand_b;
            cnt  <= '0;
            if (op == OP_RSV) begin
              err_q <= 1'b1;
              res_q <= '0;
              flg_q <= '0;
            end
          end
        end
        ST_NEG: hi <= sum;
        ST_ADD: begin
          res_q <= {{WIDTH{1'b0}}, sum};
          flg_q <= alu_flg;
        end
        ST_MUL: begin
          hi  <= prod_nx[2*WIDTH-1:WIDTH];
          lo  <= prod_nx[WIDTH-1:0];
          cnt <= cnt + CW'(1);
          if (last_iter) begin
            res_q <= prod_nx;
            flg_q <= mul_flg;
          end
        end
        ST_DONE: if (out_ready) err_q <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl.
// Hand-computed vectors checked with immediate assertions.
module tb_alu_seq_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  op = 2'b00;
  logic [7:0]  operand_a = '0;
  logic [7:0]  operand_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] result;
  logic [3:0]  flags;
  logic        err;

  int vectors = 0;
  int miscompares = 0;
  int lat;

  alu_seq_ctrl dut (
    .CLK       (CLK),
    .RST       (RST),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags),
    .err       (err)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic send(input logic [1:0] o, input logic [7:0] a,
                      input logic [7:0] b);
    op        = o;
    operand_a = a;
    operand_b = b;
    in_valid  = 1'b1;
    step();
    in_valid  = 1'b0;
  endtask

  task automatic wait_out(output int l);
    l = 1;
    while (!out_valid && l < 20) begin
      step();
      l++;
    end
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, ".ov_clr"}, 16'(out_valid), 16'h0);
    chk({tag, ".ir_up"}, 16'(in_ready), 16'h1);
  endtask

  task automatic txn(input string tag, input logic [1:0] o,
                     input logic [7:0] a, input logic [7:0] b,
                     input int el, input logic [15:0] er,
                     input logic [3:0] ef, input logic ee);
    int l;
    chk({tag, ".ir"}, 16'(in_ready), 16'h1);
    send(o, a, b);
    wait_out(l);
    chk({tag, ".lat"}, 16'(l), 16'(el));
    chk({tag, ".res"}, result, er);
    chk({tag, ".flg"}, 16'(flags), 16'(ef));
    chk({tag, ".err"}, 16'(err), 16'(ee));
    consume(tag);
  endtask

  initial begin
    RST = 1'b1;
    step();
    step();
    chk("rst.ov", 16'(out_valid), 16'h0);
    chk("rst.ir", 16'(in_ready), 16'h0);
    chk("rst.res", result, 16'h0);
    chk("rst.flg", 16'(flags), 16'h0);
    chk("rst.err", 16'(err), 16'h0);
    RST = 1'b0;
    #1;
    chk("rel.ir", 16'(in_ready), 16'h1);

    txn("add7f", 2'b00, 8'h7F, 8'h01, 2, 16'h0080, 4'b0101, 1'b0);
    txn("addff", 2'b00, 8'hFF, 8'h01, 2, 16'h0000, 4'b1010, 1'b0);
    txn("sub55", 2'b01, 8'h05, 8'h05, 3, 16'h0000, 4'b1010, 1'b0);
    txn("sub80", 2'b01, 8'h00, 8'h80, 3, 16'h0080, 4'b0101, 1'b0);
    txn("sub_v", 2'b01, 8'h80, 8'h01, 3, 16'h007F, 4'b0011, 1'b0);
    txn("mulff", 2'b10, 8'hFF, 8'hFF, 9, 16'hFE01, 4'b0010, 1'b0);
    txn("mul00", 2'b10, 8'h00, 8'h37, 9, 16'h0000, 4'b1000, 1'b0);
    txn("mul0d", 2'b10, 8'h0D, 8'h0B, 9, 16'h008F, 4'b0000, 1'b0);

    // backpressure with an ignored request
    send(2'b00, 8'h10, 8'h20);
    wait_out(lat);
    chk("bp.lat", 16'(lat), 16'd2);
    op        = 2'b10;
    operand_a = 8'hAA;
    operand_b = 8'h55;
    in_valid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp.ov", 16'(out_valid), 16'h1);
      chk("bp.res", result, 16'h0030);
      chk("bp.ir", 16'(in_ready), 16'h0);
      step();
    end
    in_valid = 1'b0;
    chk("bp.flg", 16'(flags), 16'h0);
    consume("bp");
    chk("bp.hold", result, 16'h0030);
    step();
    chk("bp.noacc", 16'(out_valid), 16'h0);
    chk("bp.idle", 16'(in_ready), 16'h1);

    // reset in the middle of a multiply
    send(2'b10, 8'h12, 8'h34);
    step();
    step();
    step();
    RST = 1'b1;
    step();
    chk("mr.ov", 16'(out_valid), 16'h0);
    chk("mr.ir", 16'(in_ready), 16'h0);
    RST = 1'b0;
    #1;
    chk("mr.ir_rel", 16'(in_ready), 16'h1);
    for (int i = 0; i < 10; i++) begin
      chk("mr.noov", 16'(out_valid), 16'h0);
      step();
    end
    txn("add12", 2'b00, 8'h01, 8'h02, 2, 16'h0003, 4'b0000, 1'b0);

    // reserved op
    txn("rsv", 2'b11, 8'hAB, 8'hCD, 1, 16'h0000, 4'b0000, 1'b1);
    chk("rsv.errclr", 16'(err), 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
